// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding register.
// Streams WIDTH-bit words one bit per clock with framing strobes.
module piso_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] hold_reg;
  logic             hold_valid;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;

  logic load;
  logic advance;
  logic accept;
  logic in_shift;

  assign in_shift = (state == SHIFT);
  assign accept   = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Reload on the last bit keeps back-to-back words gapless.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt != LAST) begin
          advance = 1'b1;
        end else if (hold_valid) begin
          load = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
    end else begin
      if (accept) begin
        hold_reg   <= din;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
      if (load) begin
        shift_reg <= hold_reg;
        bit_cnt   <= '0;
      end else if (advance) begin
        if (MSB_FIRST) begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
        end else begin
          shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
        end
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sout = IDLE_BIT;
    if (in_shift) begin
      sout = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    end
  end

  assign din_ready  = !hold_valid && !rst;
  assign sout_valid = in_shift;
  assign sof        = in_shift && (bit_cnt == '0);
  assign eof        = in_shift && (bit_cnt == LAST);
  assign busy       = hold_valid || in_shift;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: bit-queue reference model, random traffic.
// Also directed single, back-to-back, backpressure, reset and LSB cases.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       sout;
  logic       sout_valid;
  logic       sof;
  logic       eof;
  logic       busy;

  logic [7:0] lsb_din = '0;
  logic       lsb_valid = 1'b0;
  logic       lsb_ready;
  logic       lsb_sout;
  logic       lsb_sout_valid;
  logic       lsb_sof;
  logic       lsb_eof;
  logic       lsb_busy;

  always #5 clk = ~clk;

  piso_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sout(sout), .sout_valid(sout_valid),
    .sof(sof), .eof(eof), .busy(busy)
  );

  piso_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)
  ) u_lsb (
    .clk(clk), .rst(rst), .din(lsb_din), .din_valid(lsb_valid),
    .din_ready(lsb_ready), .sout(lsb_sout), .sout_valid(lsb_sout_valid),
    .sof(lsb_sof), .eof(lsb_eof), .busy(lsb_busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference: bits still to send, plus a one-word holding slot.
  bit         q[$];
  bit         hold_full = 1'b0;
  logic [7:0] hold_word = '0;
  bit         m_acc = 1'b0;
  bit         stall = 1'b0;

  logic [7:0] pend[$];
  bit         got[$];
  logic [5:0] o_vec;
  logic [5:0] e_vec;

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q.push_back(w[i]);
  endtask

  task automatic drive_cycle();
    din_valid = (pend.size() > 0) && !stall;
    din = (pend.size() > 0) ? pend[0] : 8'($urandom);
    @(posedge clk);
    if (rst) begin
      q.delete();
      hold_full = 1'b0;
      m_acc = 1'b0;
    end else begin
      m_acc = din_valid && !hold_full;
      if (q.size() > 0) void'(q.pop_front());
      if (q.size() == 0 && hold_full) begin
        push_word(hold_word);
        hold_full = 1'b0;
      end
      if (m_acc) begin
        hold_word = din;
        hold_full = 1'b1;
      end
    end
    if (m_acc) void'(pend.pop_front());
    #1;
    o_vec = {sout_valid, sout, sof, eof, busy, din_ready};
    e_vec = {q.size() > 0, (q.size() > 0) ? q[0] : 1'b0,
             q.size() == 8, q.size() == 1,
             hold_full || (q.size() > 0), !hold_full && !rst};
    if (sout_valid) got.push_back(sout);
  endtask

  function automatic logic [31:0] pack_got();
    logic [31:0] v = '0;
    foreach (got[i]) v = {v[30:0], got[i]};
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive_cycle();
    checks++;
    if (o_vec !== 6'b000000) begin
      errors++;
      $display("FAIL reset_hold: got %b want 000000", o_vec);
    end
    drive_cycle();
    checks++;
    if (o_vec !== e_vec) begin
      errors++;
      $display("FAIL reset_model: got %b want %b", o_vec, e_vec);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({sout_valid, sout, sof, eof, busy, din_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_release: got %b want 000001",
               {sout_valid, sout, sof, eof, busy, din_ready});
    end
  endtask

  task automatic test_single();
    int sof_at = -1;
    int eof_at = -1;
    int n_sof = 0;
    int n_eof = 0;
    logic [5:0] after;
    got.delete();
    pend.push_back(8'hB4);
    after = '1;
    for (int c = 0; c < 12; c++) begin
      drive_cycle();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("FAIL single_c%0d: got %b want %b", c, o_vec, e_vec);
      end
      if (sof) begin n_sof++; sof_at = c; end
      if (eof) begin n_eof++; eof_at = c; end
      if (c == 9) after = o_vec;
    end
    checks++;
    if (pack_got() !== 32'hB4 || got.size() != 8) begin
      errors++;
      $display("FAIL single_bits: got %h/%0d want b4/8",
               pack_got(), got.size());
    end
    checks++;
    if (sof_at != 1 || n_sof != 1) begin
      errors++;
      $display("FAIL single_sof: got cyc %0d n %0d want 1 1", sof_at, n_sof);
    end
    checks++;
    if (eof_at != 8 || n_eof != 1) begin
      errors++;
      $display("FAIL single_eof: got cyc %0d n %0d want 8 1", eof_at, n_eof);
    end
    checks++;
    if (after[5:4] !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got %b want 00", after[5:4]);
    end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    int best = 0;
    got.delete();
    pend.push_back(8'hB4);
    pend.push_back(8'h0F);
    for (int c = 0; c < 24; c++) begin
      drive_cycle();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("FAIL b2b_c%0d: got %b want %b", c, o_vec, e_vec);
      end
      run = sout_valid ? run + 1 : 0;
      if (run > best) best = run;
    end
    checks++;
    if (pack_got() !== 32'hB40F || best != 16) begin
      errors++;
      $display("FAIL b2b_stream: got %h run %0d want b40f run 16",
               pack_got(), best);
    end
  endtask

  task automatic test_backpressure();
    got.delete();
    pend.push_back(8'h01);
    pend.push_back(8'h80);
    pend.push_back(8'hFF);
    for (int c = 0; c < 32; c++) begin
      drive_cycle();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("FAIL bp_c%0d: got %b want %b", c, o_vec, e_vec);
      end
    end
    checks++;
    if (pack_got() !== 32'h0180FF || got.size() != 24 || pend.size() != 0) begin
      errors++;
      $display("FAIL bp_stream: got %h/%0d pend %0d want 0180ff/24 pend 0",
               pack_got(), got.size(), pend.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (pend.size() < 3 && $urandom_range(0, 3) == 0)
        pend.push_back(8'($urandom));
      stall = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 80) == 0);
      drive_cycle();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("FAIL rand_c%0d: got %b want %b", c, o_vec, e_vec);
      end
    end
    stall = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      drive_cycle();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("FAIL drain_c%0d: got %b want %b", c, o_vec, e_vec);
      end
    end
    checks++;
    if (pend.size() != 0 || o_vec !== 6'b000001) begin
      errors++;
      $display("FAIL rand_drain: pend %0d out %b want 0 000001",
               pend.size(), o_vec);
    end
  endtask

  task automatic test_reset_mid();
    got.delete();
    pend.push_back(8'hFF);
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      drive_cycle();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("FAIL rmid_c%0d: got %b want %b", c, o_vec, e_vec);
      end
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL rmid_timeout: got %0d bits want 3", got.size());
    end
    rst = 1'b1;
    drive_cycle();
    checks++;
    if (o_vec !== 6'b000000) begin
      errors++;
      $display("FAIL rmid_rst: got %b want 000000", o_vec);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({sout_valid, sout, sof, eof, busy, din_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL rmid_release: got %b want 000001",
               {sout_valid, sout, sof, eof, busy, din_ready});
    end
    got.delete();
    pend.push_back(8'hA5);
    for (int c = 0; c < 12; c++) begin
      drive_cycle();
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("FAIL rmid2_c%0d: got %b want %b", c, o_vec, e_vec);
      end
    end
    checks++;
    if (pack_got() !== 32'hA5 || got.size() != 8) begin
      errors++;
      $display("FAIL rmid_word: got %h/%0d want a5/8", pack_got(), got.size());
    end
  endtask

  task automatic test_lsb();
    logic [7:0] w = 8'hB4;
    bit lb[$];
    int sof_idx = -1;
    lsb_din = w;
    lsb_valid = 1'b1;
    @(posedge clk);
    #1;
    lsb_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk);
      #1;
      if (lsb_sout_valid) begin
        if (lsb_sof) sof_idx = lb.size();
        lb.push_back(lsb_sout);
      end
    end
    checks++;
    if (lb.size() != 8 || sof_idx != 0) begin
      errors++;
      $display("FAIL lsb_len: got %0d sof %0d want 8 0", lb.size(), sof_idx);
    end
    for (int i = 0; i < 8 && i < lb.size(); i++) begin
      checks++;
      if (lb[i] !== w[i]) begin
        errors++;
        $display("FAIL lsb_bit%0d: got %b want %b", i, lb[i], w[i]);
      end
    end
  endtask

  task automatic test_detector();
    bit raw[$];
    int pulses = 0;
    got.delete();
    pend.push_back(8'b0110_0000);
    for (int c = 0; c < 14; c++) begin
      drive_cycle();
      raw.push_back(sout);
      checks++;
      if (o_vec !== e_vec) begin
        errors++;
        $display("FAIL det_c%0d: got %b want %b", c, o_vec, e_vec);
      end
    end
    for (int i = 2; i < raw.size(); i++)
      if (raw[i] == 1'b0 && raw[i-1] && raw[i-2]) pulses++;
    checks++;
    if (pulses != 1 || pack_got() !== 32'h60) begin
      errors++;
      $display("FAIL det_pulses: got %0d word %h want 1 60",
               pulses, pack_got());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lsb();
    test_reset_mid();
    test_detector();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock. It sits directly upstream of the team's serial Mealy sequence detector and drives that block's single-bit input. A one-word holding register sits in front of the shift register, so consecutive words stream with no idle bit between them. Framing strobes mark word boundaries for debug and downstream alignment.

## Interface
- WIDTH, 8: word width in bits. Legal values are 2 or more.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- IDLE_BIT, 1'b0: value driven on sout when no bit is valid.
- clk  input  1  rising-edge clock. One clock; synchronous design throughout.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  holding register is empty. Equals !hold_valid && !rst.
- sout  output  1  serial bit. Feeds the detector's `in` port.
- sout_valid  output  1  sout carries a data bit this cycle.
- sof  output  1  current sout is the first bit of a word.
- eof  output  1  current sout is the last bit of a word.
- busy  output  1  hold register or shift register occupied.

## Operation
- Storage elements:
  - hold_reg[WIDTH-1:0] with flag hold_valid.
  - shift_reg[WIDTH-1:0].
  - bit_cnt, $clog2(WIDTH) bits.
  - FSM with states IDLE and SHIFT.
- Accept rule: a word transfers when din_valid && din_ready at a rising edge. At that edge hold_reg <= din and hold_valid <= 1.
  - din is ignored when din_ready=0.
  - din_valid may drop without a transfer. No penalty.
- FSM transitions:
  - IDLE to SHIFT: hold_valid=1. Load shift_reg <= hold_reg, set hold_valid <= 0, bit_cnt <= 0.
  - SHIFT, bit_cnt < WIDTH-1: shift one bit. Left shift if MSB_FIRST, right shift otherwise. bit_cnt <= bit_cnt+1.
  - SHIFT, bit_cnt == WIDTH-1, hold_valid=1: reload from hold_reg, clear hold_valid, bit_cnt <= 0. Stay in SHIFT. This is the back-to-back case.
  - SHIFT, bit_cnt == WIDTH-1, hold_valid=0: go to IDLE.
- Outputs, all registered state only, no din-to-output path:
  - sout = shift_reg[WIDTH-1] when MSB_FIRST, else shift_reg[0]. Forced to IDLE_BIT when state is IDLE.
  - sout_valid = (state == SHIFT).
  - sof = SHIFT && bit_cnt==0.
  - eof = SHIFT && bit_cnt==WIDTH-1.
  - busy = hold_valid || (state==SHIFT).
- Arithmetic: bit_cnt never exceeds WIDTH-1. No wrap beyond that, since it is reloaded or cleared at WIDTH-1.
- Simultaneous accept and unload cannot occur. din_ready depends on the registered hold_valid, so a new word is accepted at the earliest on the edge after hold_reg empties.
- Reset, at any time including mid-word:
  - state=IDLE, hold_valid=0, bit_cnt=0, shift_reg=0.
  - Partial and held words are discarded and never resumed.
- Output values while rst=1 and on the first cycle after rst falls: sout=IDLE_BIT, sout_valid=0, sof=0, eof=0, busy=0. din_ready=0 while rst=1 and 1 after rst falls.

## Timing
- Latency: a word accepted at edge k produces its first bit (sof=1) in the cycle after edge k+1. Its last bit (eof=1) appears in the cycle after edge k+WIDTH.
- Throughput: one bit per clock sustained. With din_valid held high, words follow with eof of word n directly followed by sof of word n+1.
- din_ready rises the cycle after hold_reg unloads. It stays low for at most WIDTH cycles under continuous traffic.
- The downstream detector samples sout every clock. IDLE_BIT=0 inserts zeros during gaps, which the detector treats as ordinary 0 input.

## Test plan
- Single word, WIDTH=8, MSB_FIRST=1, din=8'hB4 accepted at edge k:
  - sout = 1,0,1,1,0,1,0,0 in cycles k+1..k+8.
  - sof only in cycle k+1, eof only in cycle k+8.
  - sout_valid=0 and sout=0 in cycle k+9.
- Back-to-back, din_valid held with 8'hB4 then 8'h0F: 16 consecutive sout_valid cycles, stream 10110100_00001111, no gap between words, din_ready low while hold full.
- Backpressure, three words 8'h01, 8'h80, 8'hFF offered continuously: each transfers exactly once, in order, 24 bits out, no duplicates.
- LSB_FIRST (MSB_FIRST=0), din=8'hB4: sout = 0,0,1,0,1,1,0,1.
- Reset mid-word: assert rst for one cycle after 3 bits of 8'hFF:
  - Next cycle sout_valid=0, sout=0, busy=0, din_ready=0 during rst, then 1.
  - A new word 8'hA5 then serializes correctly from sof.
- End-to-end with the sequence detector: serialize 8'b01100000 MSB first. Detector `out` pulses 1 on the first 0 following the 11 pair. No extra pulses during idle zeros.
